// File: rtl/fp_pkg.sv
// Shared binary32 definitions and helpers for the floating-point datapath.
// Holds field constants, classification, leading-zero count and the common round/pack step.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] PINF = 32'h7F800000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp_t;

    function automatic fp_t unpack(input logic [31:0] x);
        return fp_t'(x);
    endfunction

    function automatic logic [31:0] pack(input fp_t f);
        return {f.sign, f.exp, f.frac};
    endfunction

    // Denormals carry a zero exponent, so they classify as zero.
    function automatic logic is_zero(input fp_t f);
        return f.exp == '0;
    endfunction

    function automatic logic is_inf(input fp_t f);
        return (f.exp == '1) && (f.frac == '0);
    endfunction

    function automatic logic is_nan(input fp_t f);
        return (f.exp == '1) && (f.frac != '0);
    endfunction

    function automatic logic [31:0] signed_zero(input logic sign);
        return {sign, 31'b0};
    endfunction

    function automatic logic [31:0] signed_inf(input logic sign);
        return PINF | {sign, 31'b0};
    endfunction

    function automatic logic [4:0] lzc28(input logic [27:0] v);
        logic [4:0] count;
        logic       found;
        count = 5'd28;
        found = 1'b0;
        for (int i = 27; i >= 0; i--) begin
            if (!found && v[i]) begin
                count = 5'(27 - i);
                found = 1'b1;
            end
        end
        return count;
    endfunction

    // Round-to-nearest-even on a normalised 24-bit significand, then saturate or flush.
    function automatic logic [31:0] round_pack(input logic sign, input logic signed [9:0] expIn,
                                               input logic [23:0] mant, input logic guard,
                                               input logic sticky);
        logic [24:0]       rounded;
        logic signed [9:0] e;
        logic [FRAC_W-1:0] frac;
        logic [31:0]       res;
        rounded = {1'b0, mant} + {24'b0, guard & (sticky | mant[0])};
        e       = expIn;
        frac    = rounded[22:0];
        if (rounded[24]) begin
            e    = expIn + 10'sd1;
            frac = rounded[23:1];
        end
        if (e >= 10'sd255) begin
            res = signed_inf(sign);
        end else if (e <= 10'sd0) begin
            res = signed_zero(sign);
        end else begin
            res = {sign, e[7:0], frac};
        end
        return res;
    endfunction

endpackage

// File: rtl/fp_add_sub.sv
// Pipelined binary32 adder/subtractor with guard/round/sticky alignment,
// leading-zero normalisation and round-to-nearest-even.
module fp_add_sub
    import fp_pkg::*;
#(
    parameter int LATENCY = 7
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic        add_sub,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result
);

    logic [31:0]       a_q, b_q;
    logic              addSub_q;
    logic [31:0]       pipe_q [LATENCY-1];
    logic [31:0]       res_d;
    fp_t               a, b;
    logic              bSign, swap, bigSign, effSub;
    logic [7:0]        bigExp, smallExp;
    logic [22:0]       bigFrac, smallFrac;
    logic [49:0]       shifted;
    logic [26:0]       aligned;
    logic [27:0]       sum, norm;
    logic [4:0]        lz;
    logic signed [9:0] normExp;

    always_comb begin
        a         = unpack(a_q);
        b         = unpack(b_q);
        // Fold subtraction into B's sign so only the effective operation matters below.
        bSign     = b.sign ^ ~addSub_q;
        swap      = {b.exp, b.frac} > {a.exp, a.frac};
        bigExp    = swap ? b.exp : a.exp;
        bigFrac   = swap ? b.frac : a.frac;
        bigSign   = swap ? bSign : a.sign;
        smallExp  = swap ? a.exp : b.exp;
        smallFrac = swap ? a.frac : b.frac;
        shifted   = {1'b1, smallFrac, 26'b0} >> (bigExp - smallExp);
        aligned   = {shifted[49:24], |shifted[23:0]};
        effSub    = a.sign ^ bSign;
        sum       = effSub ? ({2'b01, bigFrac, 3'b0} - {1'b0, aligned})
                           : ({2'b01, bigFrac, 3'b0} + {1'b0, aligned});
        lz        = lzc28(sum);
        norm      = sum << lz;
        normExp   = $signed({2'b00, bigExp}) + 10'sd1 - $signed({5'b00000, lz});

        if (is_nan(a) || is_nan(b)) begin
            res_d = QNAN;
        end else if (is_inf(a) && is_inf(b)) begin
            res_d = effSub ? QNAN : a_q;
        end else if (is_inf(a)) begin
            res_d = a_q;
        end else if (is_inf(b)) begin
            res_d = signed_inf(bSign);
        end else if (is_zero(a) && is_zero(b)) begin
            res_d = signed_zero(a.sign & bSign);
        end else if (is_zero(b)) begin
            res_d = a_q;
        end else if (is_zero(a)) begin
            res_d = {bSign, b.exp, b.frac};
        end else if (sum == '0) begin
            res_d = '0;
        end else begin
            res_d = round_pack(bigSign, normExp, norm[27:4], norm[3], |norm[2:0]);
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            a_q      <= '0;
            b_q      <= '0;
            addSub_q <= 1'b0;
            for (int i = 0; i < LATENCY - 1; i++) pipe_q[i] <= '0;
        end else if (clk_en) begin
            a_q       <= dataa;
            b_q       <= datab;
            addSub_q  <= add_sub;
            pipe_q[0] <= res_d;
            for (int i = 1; i < LATENCY - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign result = pipe_q[LATENCY-2];

endmodule

// File: rtl/fp_mult.sv
// Pipelined binary32 multiplier: operands registered, product computed and rounded,
// then carried through the remaining stages together with its NaN flag.
module fp_mult
    import fp_pkg::*;
#(
    parameter int LATENCY = 5
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        nan
);

    logic [31:0]       a_q, b_q;
    logic [32:0]       pipe_q [LATENCY-1];
    logic [31:0]       res_d;
    logic              nan_d;
    fp_t               a, b;
    logic              sign;
    logic [47:0]       prod;
    logic signed [9:0] prodExp;

    always_comb begin
        a       = unpack(a_q);
        b       = unpack(b_q);
        sign    = a.sign ^ b.sign;
        prod    = 48'({1'b1, a.frac}) * 48'({1'b1, b.frac});
        prodExp = $signed({2'b00, a.exp}) + $signed({2'b00, b.exp}) - 10'(BIAS);
        nan_d   = 1'b0;
        if (is_nan(a) || is_nan(b) || (is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b))) begin
            res_d = QNAN;
            nan_d = 1'b1;
        end else if (is_inf(a) || is_inf(b)) begin
            res_d = signed_inf(sign);
        end else if (is_zero(a) || is_zero(b)) begin
            res_d = signed_zero(sign);
        end else if (prod[47]) begin
            // Product in [2,4): one-bit normalisation shift.
            res_d = round_pack(sign, prodExp + 10'sd1, prod[47:24], prod[23], |prod[22:0]);
        end else begin
            res_d = round_pack(sign, prodExp, prod[46:23], prod[22], |prod[21:0]);
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            a_q <= '0;
            b_q <= '0;
            for (int i = 0; i < LATENCY - 1; i++) pipe_q[i] <= '0;
        end else if (clk_en) begin
            a_q       <= dataa;
            b_q       <= datab;
            pipe_q[0] <= {nan_d, res_d};
            for (int i = 1; i < LATENCY - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign {nan, result} = pipe_q[LATENCY-2];

endmodule

// File: rtl/fp_arith_core.sv
// Floating-point datapath top: one pipelined multiplier and one pipelined
// adder/subtractor sharing clock, asynchronous clear and clock enable.
module fp_arith_core #(
    parameter int MULT_LATENCY = 5,
    parameter int ADD_LATENCY  = 7
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic [31:0] mul_dataa,
    input  logic [31:0] mul_datab,
    output logic [31:0] mul_result,
    output logic        mul_nan,
    input  logic        add_sub,
    input  logic [31:0] add_dataa,
    input  logic [31:0] add_datab,
    output logic [31:0] add_result
);

    fp_mult #(.LATENCY(MULT_LATENCY)) u_mult (
        .clock  (clock),
        .aclr   (aclr),
        .clk_en (clk_en),
        .dataa  (mul_dataa),
        .datab  (mul_datab),
        .result (mul_result),
        .nan    (mul_nan)
    );

    fp_add_sub #(.LATENCY(ADD_LATENCY)) u_add_sub (
        .clock   (clock),
        .aclr    (aclr),
        .clk_en  (clk_en),
        .add_sub (add_sub),
        .dataa   (add_dataa),
        .datab   (add_datab),
        .result  (add_result)
    );

endmodule

// File: tb/tb_fp_arith_core.sv
// Self-checking bench for fp_arith_core: directed scenarios plus a randomized
// stream with random stalls, checked against a real-arithmetic reference model.
module tb_fp_arith_core;

    localparam int MUL_LAT = 5;
    localparam int ADD_LAT = 7;

    localparam logic [31:0] F_0P25 = 32'h3E800000;
    localparam logic [31:0] F_1    = 32'h3F800000;
    localparam logic [31:0] F_1P5  = 32'h3FC00000;
    localparam logic [31:0] F_2    = 32'h40000000;
    localparam logic [31:0] F_3    = 32'h40400000;
    localparam logic [31:0] F_5    = 32'h40A00000;
    localparam logic [31:0] F_6    = 32'h40C00000;
    localparam logic [31:0] F_QNAN = 32'h7FC00000;
    localparam logic [31:0] F_PINF = 32'h7F800000;

    logic        clock = 1'b0;
    logic        aclr;
    logic        clk_en;
    logic [31:0] mul_dataa, mul_datab, mul_result;
    logic        mul_nan;
    logic        add_sub;
    logic [31:0] add_dataa, add_datab, add_result;

    int errors = 0;
    int checks = 0;

    fp_arith_core #(.MULT_LATENCY(MUL_LAT), .ADD_LATENCY(ADD_LAT)) dut (
        .clock      (clock),
        .aclr       (aclr),
        .clk_en     (clk_en),
        .mul_dataa  (mul_dataa),
        .mul_datab  (mul_datab),
        .mul_result (mul_result),
        .mul_nan    (mul_nan),
        .add_sub    (add_sub),
        .add_dataa  (add_dataa),
        .add_datab  (add_datab),
        .add_result (add_result)
    );

    always #5 clock = ~clock;

    // Each call advances past n rising edges and returns on a falling edge.
    task automatic cycle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic applyStimulus(input logic [31:0] ma, input logic [31:0] mb, input logic as,
                                 input logic [31:0] aa, input logic [31:0] ab);
        mul_dataa = ma;
        mul_datab = mb;
        add_sub   = as;
        add_dataa = aa;
        add_datab = ab;
    endtask

    task automatic applyZeros();
        applyStimulus(32'h0, 32'h0, 1'b1, 32'h0, 32'h0);
    endtask

    // Reference model: IEEE rules applied to exact real-valued arithmetic.
    function automatic logic isNaN(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    endfunction

    function automatic logic isInf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
    endfunction

    function automatic logic isZero(input logic [31:0] x);
        return x[30:23] == 8'h00;
    endfunction

    function automatic real toReal(input logic [31:0] x);
        int          e;
        logic [63:0] d;
        e = int'(x[30:23]) - 127 + 1023;
        d = {x[31], e[10:0], x[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] toSingle(input real v);
        logic [63:0] d;
        logic [24:0] m;
        logic [28:0] rem;
        int          e;
        d   = $realtobits(v);
        e   = int'(d[62:52]) - 1023 + 127;
        m   = {2'b01, d[51:29]};
        rem = d[28:0];
        if (rem > 29'h10000000 || (rem == 29'h10000000 && m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= 255) return {d[63], 8'hFF, 23'h0};
        if (e <= 0) return {d[63], 31'h0};
        return {d[63], e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] modelMul(input logic [31:0] a, input logic [31:0] b);
        logic s;
        s = a[31] ^ b[31];
        if (isNaN(a) || isNaN(b)) return F_QNAN;
        if ((isInf(a) && isZero(b)) || (isZero(a) && isInf(b))) return F_QNAN;
        if (isInf(a) || isInf(b)) return {s, 8'hFF, 23'h0};
        if (isZero(a) || isZero(b)) return {s, 31'h0};
        return toSingle(toReal(a) * toReal(b));
    endfunction

    function automatic logic [31:0] modelAdd(input logic [31:0] a, input logic [31:0] b, input logic op);
        logic [31:0] nb;
        real         s;
        nb = {b[31] ^ ~op, b[30:0]};
        if (isNaN(a) || isNaN(nb)) return F_QNAN;
        if (isInf(a) && isInf(nb)) return (a[31] != nb[31]) ? F_QNAN : a;
        if (isInf(a)) return a;
        if (isInf(nb)) return nb;
        if (isZero(a) && isZero(nb)) return (a[31] && nb[31]) ? 32'h80000000 : 32'h0;
        if (isZero(nb)) return a;
        if (isZero(a)) return nb;
        s = toReal(a) + toReal(nb);
        if (s == 0.0) return 32'h0;
        return toSingle(s);
    endfunction

    function automatic logic [31:0] randOperand(input int centre, input int spread);
        int   kind;
        int   e;
        logic s;
        kind = int'($urandom_range(0, 19));
        s    = 1'($urandom);
        case (kind)
            0: return {s, 31'h0};
            1: return {s, 8'h00, 23'($urandom_range(1, 23'h7FFFFF))};
            2: return {s, 8'hFF, 23'h0};
            3: return {s, 8'hFF, 23'($urandom_range(1, 23'h7FFFFF))};
            default: begin
                e = centre + int'($urandom_range(0, 2 * spread)) - spread;
                if (e < 1) e = 1;
                if (e > 254) e = 254;
                return {s, e[7:0], 23'($urandom)};
            end
        endcase
    endfunction

    task automatic test_reset();
        aclr   = 1'b1;
        clk_en = 1'b1;
        applyZeros();
        cycle(2);
        checks++;
        if (mul_result !== 32'h0) begin errors++; $display("[TB] FAIL reset_mul: got %h, expected %h", mul_result, 32'h0); end
        checks++;
        if (mul_nan !== 1'b0) begin errors++; $display("[TB] FAIL reset_nan: got %b, expected 0", mul_nan); end
        checks++;
        if (add_result !== 32'h0) begin errors++; $display("[TB] FAIL reset_add: got %h, expected %h", add_result, 32'h0); end
        aclr = 1'b0;
        cycle(1);
    endtask

    task automatic test_mult_basic();
        applyStimulus(F_2, F_3, 1'b1, 32'h0, 32'h0);
        cycle(1);
        applyZeros();
        cycle(MUL_LAT - 2);
        checks++;
        if (mul_result !== 32'h0) begin errors++; $display("[TB] FAIL mul_early: got %h, expected %h", mul_result, 32'h0); end
        cycle(1);
        checks++;
        if (mul_result !== F_6) begin errors++; $display("[TB] FAIL mul_2x3: got %h, expected %h", mul_result, F_6); end
        checks++;
        if (mul_nan !== 1'b0) begin errors++; $display("[TB] FAIL mul_2x3_nan: got %b, expected 0", mul_nan); end
        cycle(2);
    endtask

    task automatic test_add_basic();
        applyStimulus(32'h0, 32'h0, 1'b1, F_1, F_1);
        cycle(1);
        applyStimulus(32'h0, 32'h0, 1'b0, F_1, F_1);
        cycle(1);
        applyStimulus(32'h0, 32'h0, 1'b1, F_1, F_1);
        cycle(1);
        applyZeros();
        cycle(ADD_LAT - 4);
        checks++;
        if (add_result !== 32'h0) begin errors++; $display("[TB] FAIL add_early: got %h, expected %h", add_result, 32'h0); end
        cycle(1);
        checks++;
        if (add_result !== F_2) begin errors++; $display("[TB] FAIL add_1p1: got %h, expected %h", add_result, F_2); end
        cycle(1);
        checks++;
        if (add_result !== 32'h0) begin errors++; $display("[TB] FAIL sub_1m1: got %h, expected %h", add_result, 32'h0); end
        cycle(1);
        checks++;
        if (add_result !== F_2) begin errors++; $display("[TB] FAIL add_1p1_again: got %h, expected %h", add_result, F_2); end
        cycle(2);
    endtask

    task automatic test_back_to_back();
        applyStimulus(32'h0, 32'h0, 1'b1, F_1P5, F_0P25);
        cycle(1);
        applyStimulus(32'h0, 32'h0, 1'b0, F_1, F_3);
        cycle(1);
        applyZeros();
        cycle(ADD_LAT - 2);
        checks++;
        if (add_result !== 32'h3FE00000) begin errors++; $display("[TB] FAIL b2b_first: got %h, expected %h", add_result, 32'h3FE00000); end
        cycle(1);
        checks++;
        if (add_result !== 32'hC0000000) begin errors++; $display("[TB] FAIL b2b_second: got %h, expected %h", add_result, 32'hC0000000); end
        cycle(2);
    endtask

    task automatic test_specials();
        applyStimulus(F_PINF, 32'h0, 1'b0, F_PINF, F_PINF);
        cycle(1);
        applyStimulus(32'h7F000000, F_2, 1'b1, 32'h80000000, 32'h80000000);
        cycle(1);
        applyStimulus(32'h7FC12345, F_1, 1'b1, F_1, 32'h7F812345);
        cycle(1);
        applyZeros();
        cycle(MUL_LAT - 3);
        checks++;
        if (mul_result !== F_QNAN) begin errors++; $display("[TB] FAIL inf_x_zero: got %h, expected %h", mul_result, F_QNAN); end
        checks++;
        if (mul_nan !== 1'b1) begin errors++; $display("[TB] FAIL inf_x_zero_nan: got %b, expected 1", mul_nan); end
        cycle(1);
        checks++;
        if (mul_result !== F_PINF) begin errors++; $display("[TB] FAIL mul_overflow: got %h, expected %h", mul_result, F_PINF); end
        checks++;
        if (mul_nan !== 1'b0) begin errors++; $display("[TB] FAIL mul_overflow_nan: got %b, expected 0", mul_nan); end
        cycle(1);
        checks++;
        if (mul_result !== F_QNAN) begin errors++; $display("[TB] FAIL mul_nan_in: got %h, expected %h", mul_result, F_QNAN); end
        checks++;
        if (mul_nan !== 1'b1) begin errors++; $display("[TB] FAIL mul_nan_in_flag: got %b, expected 1", mul_nan); end
        checks++;
        if (add_result !== F_QNAN) begin errors++; $display("[TB] FAIL inf_minus_inf: got %h, expected %h", add_result, F_QNAN); end
        cycle(1);
        checks++;
        if (add_result !== 32'h80000000) begin errors++; $display("[TB] FAIL neg_zero_sum: got %h, expected %h", add_result, 32'h80000000); end
        cycle(1);
        checks++;
        if (add_result !== F_QNAN) begin errors++; $display("[TB] FAIL add_nan_in: got %h, expected %h", add_result, F_QNAN); end
        cycle(2);
    endtask

    task automatic test_stall();
        applyStimulus(F_2, F_3, 1'b1, F_1, F_1);
        cycle(1);
        clk_en = 1'b0;
        applyStimulus(F_5, F_5, 1'b1, F_5, F_5);
        for (int k = 0; k < 4; k++) begin
            cycle(1);
            checks++;
            if (mul_result !== 32'h0) begin errors++; $display("[TB] FAIL stall_mul_hold: got %h, expected %h", mul_result, 32'h0); end
            checks++;
            if (add_result !== 32'h0) begin errors++; $display("[TB] FAIL stall_add_hold: got %h, expected %h", add_result, 32'h0); end
        end
        clk_en = 1'b1;
        applyZeros();
        cycle(MUL_LAT - 2);
        checks++;
        if (mul_result !== 32'h0) begin errors++; $display("[TB] FAIL stall_mul_early: got %h, expected %h", mul_result, 32'h0); end
        cycle(1);
        checks++;
        if (mul_result !== F_6) begin errors++; $display("[TB] FAIL stall_mul_result: got %h, expected %h", mul_result, F_6); end
        checks++;
        if (add_result !== 32'h0) begin errors++; $display("[TB] FAIL stall_add_early: got %h, expected %h", add_result, 32'h0); end
        cycle(ADD_LAT - MUL_LAT);
        checks++;
        if (add_result !== F_2) begin errors++; $display("[TB] FAIL stall_add_result: got %h, expected %h", add_result, F_2); end
        cycle(2);
    endtask

    task automatic test_aclr();
        applyStimulus(F_2, F_3, 1'b1, F_1, F_1);
        cycle(ADD_LAT + 1);
        checks++;
        if (mul_result !== F_6) begin errors++; $display("[TB] FAIL pre_aclr_mul: got %h, expected %h", mul_result, F_6); end
        checks++;
        if (add_result !== F_2) begin errors++; $display("[TB] FAIL pre_aclr_add: got %h, expected %h", add_result, F_2); end
        #2 aclr = 1'b1;
        #1;
        checks++;
        if (mul_result !== 32'h0) begin errors++; $display("[TB] FAIL aclr_mul_now: got %h, expected %h", mul_result, 32'h0); end
        checks++;
        if (add_result !== 32'h0) begin errors++; $display("[TB] FAIL aclr_add_now: got %h, expected %h", add_result, 32'h0); end
        cycle(1);
        applyZeros();
        aclr = 1'b0;
        for (int k = 0; k < ADD_LAT + 2; k++) begin
            checks++;
            if (mul_result !== 32'h0) begin errors++; $display("[TB] FAIL aclr_flush_mul: got %h, expected %h", mul_result, 32'h0); end
            checks++;
            if (mul_nan !== 1'b0) begin errors++; $display("[TB] FAIL aclr_flush_nan: got %b, expected 0", mul_nan); end
            checks++;
            if (add_result !== 32'h0) begin errors++; $display("[TB] FAIL aclr_flush_add: got %h, expected %h", add_result, 32'h0); end
            cycle(1);
        end
        applyStimulus(F_2, F_3, 1'b1, F_1P5, F_0P25);
        cycle(1);
        applyZeros();
        cycle(MUL_LAT - 1);
        checks++;
        if (mul_result !== F_6) begin errors++; $display("[TB] FAIL post_aclr_mul: got %h, expected %h", mul_result, F_6); end
        cycle(ADD_LAT - MUL_LAT);
        checks++;
        if (add_result !== 32'h3FE00000) begin errors++; $display("[TB] FAIL post_aclr_add: got %h, expected %h", add_result, 32'h3FE00000); end
        cycle(2);
    endtask

    // Expected output after n enabled edges is the result of the op issued LATENCY edges earlier.
    task automatic test_random(input int nCycles);
        logic [31:0] mulHist[$];
        logic [31:0] addHist[$];
        logic [31:0] ma, mb, aa, ab, expMul, expAdd;
        logic        as, en;
        int          n;
        int          centre;
        aclr = 1'b1;
        #2 aclr = 1'b0;
        n = 0;
        for (int i = 0; i < nCycles; i++) begin
            expMul = (n >= MUL_LAT) ? mulHist[n - MUL_LAT] : 32'h0;
            expAdd = (n >= ADD_LAT) ? addHist[n - ADD_LAT] : 32'h0;
            checks++;
            if (mul_result !== expMul) begin errors++; $display("[TB] FAIL rand_mul[%0d]: got %h, expected %h", i, mul_result, expMul); end
            checks++;
            if (mul_nan !== isNaN(expMul)) begin errors++; $display("[TB] FAIL rand_nan[%0d]: got %b, expected %b", i, mul_nan, isNaN(expMul)); end
            checks++;
            if (add_result !== expAdd) begin errors++; $display("[TB] FAIL rand_add[%0d]: got %h, expected %h", i, add_result, expAdd); end
            ma     = randOperand(127, 90);
            mb     = randOperand(127, 90);
            centre = int'($urandom_range(1, 254));
            aa     = randOperand(centre, 0);
            ab     = randOperand(centre, 20);
            as     = 1'($urandom);
            en     = ($urandom_range(0, 3) != 0);
            applyStimulus(ma, mb, as, aa, ab);
            clk_en = en;
            if (en) begin
                mulHist.push_back(modelMul(ma, mb));
                addHist.push_back(modelAdd(aa, ab, as));
                n++;
            end
            cycle(1);
        end
        clk_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_add_basic();
        test_back_to_back();
        test_specials();
        test_stall();
        test_aclr();
        test_random(600);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_arith_core.md
# fp_arith_core

Pipelined IEEE-754 single-precision arithmetic core with one fixed-latency multiplier and one fixed-latency adder/subtractor. It serves as the floating-point datapath for the encoder's LPC/alpha computation blocks. Both operators are fully pipelined and accept a new operand pair every enabled cycle. A shared clock enable stalls both pipelines together.

## Interface
Parameters:
- MULT_LATENCY, 5: number of enabled clock edges from multiplier operands to `mul_result`.
- ADD_LATENCY, 7: number of enabled clock edges from adder operands to `add_result`.

Ports. One clock; reset is asynchronous and active-high.
- clock  in  1  rising-edge clock.
- aclr  in  1  asynchronous active-high reset; clears every pipeline stage.
- clk_en  in  1  pipeline advance enable, shared by both operators.
- mul_dataa  in  32  multiplier operand A (binary32).
- mul_datab  in  32  multiplier operand B (binary32).
- mul_result  out  32  A*B (binary32).
- mul_nan  out  1  result is NaN; aligned with `mul_result`.
- add_sub  in  1  1 = add, 0 = subtract; registered with the operands.
- add_dataa  in  32  adder operand A.
- add_datab  in  32  adder operand B.
- add_result  out  32  A+B or A−B.

## Operation
- Format is binary32: sign[31], exp[30:23] (bias 127), frac[22:0].
- Rounding is round-to-nearest-even.
- Denormal inputs are treated as signed zero. Denormal results are flushed to +0 or −0, keeping the true sign.
- Exponent overflow gives ±Inf (0x7F800000 | sign).
- NaN cases:
  - Any NaN input gives canonical quiet NaN 0x7FC00000.
  - Inf×0 gives 0x7FC00000 and `mul_nan=1`.
  - Inf−Inf (effective subtraction) gives 0x7FC00000.
- `mul_nan` is 1 exactly when `mul_result` is NaN.
- Multiply:
  - sign = XOR of input signs.
  - 24×24 mantissa product, normalise by at most 1 bit, round.
- Add/subtract:
  - Effective operation = `add_sub` XOR the sign difference.
  - Align the smaller operand using guard/round/sticky bits.
  - Add or subtract the mantissas, then normalise with a leading-zero count, then round.
  - An exact zero result is +0, except (−0)+(−0) = −0.
- `add_sub` is sampled in the same cycle as its operands, so it can change every cycle.

## Timing
- Operands are sampled on every rising edge with `clk_en=1`.
- The result for operands sampled at enabled edge k appears after enabled edge k+LATENCY−1 (5 edges multiplier, 7 edges adder). It is valid to read once LATENCY enabled edges have occurred since sampling.
- Throughput is one operation per enabled cycle per operator; there is no handshake.
- Pipeline sequencing is left to the user: sequencers shift a valid bit in parallel.
- `clk_en=0`: all stages hold; outputs stay constant; inputs are ignored.
- Stall cycles do not count toward latency.
- `aclr=1` at any time, including mid-operation:
  - All stages clear immediately (asynchronously).
  - `mul_result=0`, `mul_nan=0`, `add_result=0`.
  - In-flight operations are discarded.
- After `aclr` deasserts, the outputs read 0x00000000 until the first real result reaches the output.
- When `aclr` and `clk_en` are both high, `aclr` wins.

## Structure
- Shared package `fp_pkg` holds:
  - binary32 field constants (EXP_W=8, FRAC_W=23, BIAS=127);
  - constants QNAN=32'h7FC00000 and PINF=32'h7F800000;
  - unpack/pack and classify functions (is_zero, is_inf, is_nan).
- Sub-modules `fp_mult` and `fp_add_sub` keep Altera-megafunction-style ports: clock, aclr, clk_en, dataa, datab, result, plus nan / add_sub respectively.
- `fp_arith_core` only instantiates these two sub-modules and wires them up.
- A small leading-zero counter function goes in `fp_pkg`.

## Test plan
- Multiply 0x40000000 × 0x40400000 (2.0×3.0) with `clk_en=1` → `mul_result`=0x40C00000 (6.0) after 5 edges, `mul_nan=0`.
- Add 0x3F800000 + 0x3F800000 with `add_sub=1` → 0x40000000 after 7 edges. Same operands with `add_sub=0` → 0x00000000.
- Back-to-back inputs: 1.5+0.25 then 1.0−3.0 on consecutive edges → 0x3FE00000 then 0xC0000000 on consecutive cycles.
- Multiply 0x7F800000 × 0x00000000 → `mul_result`=0x7FC00000 and `mul_nan=1`. Multiply 0x7F000000 × 0x40000000 → 0x7F800000.
- Issue 2.0×3.0, hold `clk_en=0` for 4 cycles, then resume → the output stays unchanged during the stall and 0x40C00000 appears after 5 enabled edges in total.
- Assert `aclr` for 1 cycle mid-pipeline with operations in flight → outputs go to 0 immediately, none of the in-flight results ever appear, and a new operation issued afterwards returns its correct result after full latency.
